// File: rtl/fetch_pkg.sv
// Shared constants and state type for the fetch unit.
// FETCH_HALT_DETECT_EN adds the HALTED state and halt-opcode detection.
package fetch_pkg;

   localparam int PC_W = 8;
   localparam int INSTR_W_DEF = 16;
   localparam logic [3:0] HALT_OPCODE = 4'hF;

   typedef enum logic [1:0] {
      ST_RUN = 2'd0,
      ST_DRAIN = 2'd1
`ifdef FETCH_HALT_DETECT_EN
      , ST_HALTED = 2'd2
`endif
   } fetch_state_e;

   function automatic logic is_halt(logic [3:0] op);
      return op == HALT_OPCODE;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {instr, pc} entries.
// Pointers wrap modulo DEPTH; count reports occupancy.
module fetch_buffer #(
   parameter int W = 24,
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic push,
   input  logic pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues ROM reads, tags them with the PC, buffers results.
// FETCH_HALT_DETECT_EN stops fetching after a halt opcode is buffered.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic [7:0] pc_in,
   output logic pc_stall,
   output logic [7:0] imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic flush,
   output logic out_valid,
   input  logic out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [7:0] out_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int LW = CW + 1;
   localparam int EW = INSTR_W + PC_W;

   fetch_state_e state_q;
   fetch_state_e state_d;

   logic fly_v;
   logic [PC_W-1:0] fly_pc;
   logic [CW-1:0] count;
   logic [EW-1:0] head;
   logic [LW-1:0] load;
   logic push;
   logic pop;
   logic issue;
   logic halt_hit;

   assign imem_addr = pc_in;
   assign out_valid = count != '0;
   assign pop = out_valid && out_ready && !flush;
   assign push = fly_v && (state_q == ST_RUN) && !flush;

`ifdef FETCH_HALT_DETECT_EN
   assign halt_hit = push && is_halt(imem_data[INSTR_W-1 -: 4]);
`else
   assign halt_hit = 1'b0;
`endif

   // A slot freed by this cycle's pop is credited, so a stream never bubbles
   assign load = LW'(count) + LW'(fly_v) - LW'(pop);

   assign pc_stall = (state_q != ST_RUN) || halt_hit ||
                     (load >= LW'(DEPTH));

   assign issue = !pc_stall && !flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fly_v <= 1'b0;
         fly_pc <= '0;
      end else if (flush) begin
         fly_v <= 1'b0;
      end else begin
         fly_v <= issue;
         if (issue) begin
            fly_pc <= pc_in;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (flush) begin
               state_d = ST_DRAIN;
            end else if (halt_hit) begin
`ifdef FETCH_HALT_DETECT_EN
               state_d = ST_HALTED;
`endif
            end
         end
         ST_DRAIN: begin
            state_d = flush ? ST_DRAIN : ST_RUN;
         end
`ifdef FETCH_HALT_DETECT_EN
         ST_HALTED: begin
            if (flush) begin
               state_d = ST_DRAIN;
            end
         end
`endif
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   fetch_buffer #(
      .W(EW),
      .DEPTH(DEPTH)
   ) u_buf (
      .clk(clk),
      .reset_n(reset_n),
      .clear(flush),
      .push(push),
      .pop(pop),
      .wdata({imem_data, fly_pc}),
      .rdata(head),
      .count(count)
   );

   assign out_instr = out_valid ? head[EW-1:PC_W] : '0;
   assign out_pc = out_valid ? head[PC_W-1:0] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic flush = 1'b0;
   logic out_ready = 1'b0;
   logic [7:0] pc_in = 8'h00;
   logic [15:0] imem_data = 16'h0000;
   logic pc_stall;
   logic out_valid;
   logic [7:0] imem_addr;
   logic [7:0] out_pc;
   logic [15:0] out_instr;

   int checks = 0;
   int errors = 0;

   logic [15:0] rom [256];

   typedef struct {
      logic [15:0] instr;
      logic [7:0] pc;
   } ent_t;

   ent_t mq[$];
   logic [7:0] fq[$];
   bit m_drain;
   bit m_halt;
   logic [7:0] pc;
   logic [7:0] obs_pc[$];
   logic [15:0] obs_instr[$];
   logic [7:0] obs_issue[$];

   fetch_unit #(
      .INSTR_W(16),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .pc_in(pc_in),
      .pc_stall(pc_stall),
      .imem_addr(imem_addr),
      .imem_data(imem_data),
      .flush(flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_data <= rom[imem_addr];

   task automatic rom_linear();
      for (int a = 0; a < 256; a++) rom[a] = 16'(16'h1000 + a);
   endtask

   task automatic check_zero(input string tag);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s out_valid got %b want 0", tag, out_valid);
      end
      checks++;
      if (pc_stall !== 1'b0) begin
         errors++;
         $display("FAIL %s pc_stall got %b want 0", tag, pc_stall);
      end
      checks++;
      if (out_instr !== 16'h0) begin
         errors++;
         $display("FAIL %s out_instr got %h want 0000", tag, out_instr);
      end
      checks++;
      if (out_pc !== 8'h0) begin
         errors++;
         $display("FAIL %s out_pc got %h want 00", tag, out_pc);
      end
   endtask

   // Holds reset over one rising edge, then releases just after a falling edge
   task automatic do_reset(input logic [7:0] start);
      reset_n = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      pc_in = start;
      @(posedge clk);
      @(negedge clk);
      #1;
      check_zero("reset");
      reset_n = 1'b1;
      mq.delete();
      fq.delete();
      m_drain = 1'b0;
      m_halt = 1'b0;
      pc = start;
      obs_pc.delete();
      obs_instr.delete();
      obs_issue.delete();
   endtask

   // One clock cycle: drive, compare against model, advance model, cross edge
   task automatic step(input bit fl, input bit rdy, input logic [7:0] tgt);
      bit ev;
      bit pop;
      bit hh;
      bit es;
      ent_t h;
      pc_in = pc;
      flush = fl;
      out_ready = rdy;
      #1;
      h.instr = 16'h0;
      h.pc = 8'h0;
      ev = mq.size() != 0;
      if (ev) h = mq[0];
      pop = ev && rdy && !fl;
      hh = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
      if (!fl && !m_drain && !m_halt && fq.size() != 0)
         hh = rom[fq[0]][15:12] == 4'hF;
`endif
      es = m_drain || m_halt || hh ||
           (mq.size() + fq.size() - int'(pop) >= DEPTH);
      checks++;
      if (out_valid !== ev) begin
         errors++;
         $display("FAIL out_valid got %b want %b t=%0t", out_valid, ev, $time);
      end
      checks++;
      if (out_instr !== h.instr) begin
         errors++;
         $display("FAIL out_instr got %h want %h t=%0t", out_instr, h.instr, $time);
      end
      checks++;
      if (out_pc !== h.pc) begin
         errors++;
         $display("FAIL out_pc got %h want %h t=%0t", out_pc, h.pc, $time);
      end
      checks++;
      if (pc_stall !== es) begin
         errors++;
         $display("FAIL pc_stall got %b want %b t=%0t", pc_stall, es, $time);
      end
      checks++;
      if (imem_addr !== pc) begin
         errors++;
         $display("FAIL imem_addr got %h want %h t=%0t", imem_addr, pc, $time);
      end
      if (out_valid && rdy && !fl) begin
         obs_pc.push_back(out_pc);
         obs_instr.push_back(out_instr);
      end
      if (!pc_stall && !fl) obs_issue.push_back(imem_addr);
      if (fl) begin
         mq.delete();
         fq.delete();
         m_drain = 1'b1;
         m_halt = 1'b0;
         pc = tgt;
      end else begin
         if (pop) void'(mq.pop_front());
         if (fq.size() != 0 && !m_drain && !m_halt) begin
            h.instr = rom[fq[0]];
            h.pc = fq[0];
            mq.push_back(h);
`ifdef FETCH_HALT_DETECT_EN
            if (h.instr[15:12] == 4'hF) m_halt = 1'b1;
`endif
         end
         fq.delete();
         if (!es) begin
            fq.push_back(pc);
            pc = pc + 8'd1;
         end
         m_drain = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_pcs(input string tag, input logic [7:0] first, input int n);
      checks++;
      if (obs_pc.size() < n) begin
         errors++;
         $display("FAIL %s count got %0d want >=%0d", tag, obs_pc.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_pc[i] !== 8'(first + 8'(i))) begin
               errors++;
               $display("FAIL %s pc[%0d] got %h want %h", tag, i, obs_pc[i],
                        8'(first + 8'(i)));
            end
         end
      end
   endtask

   task automatic test_reset();
      rom_linear();
      do_reset(8'h00);
      step(1'b0, 1'b1, 8'h00);
   endtask

   task automatic test_stream();
      rom_linear();
      do_reset(8'h00);
      repeat (8) step(1'b0, 1'b1, 8'h00);
      check_pcs("stream", 8'h00, 6);
      for (int i = 0; i < 4 && i < obs_instr.size(); i++) begin
         checks++;
         if (obs_instr[i] !== 16'(16'h1000 + i)) begin
            errors++;
            $display("FAIL stream instr[%0d] got %h want %h", i, obs_instr[i],
                     16'(16'h1000 + i));
         end
      end
   endtask

   task automatic test_backpressure();
      rom_linear();
      do_reset(8'h00);
      repeat (5) step(1'b0, 1'b0, 8'h00);
      checks++;
      if (obs_issue.size() != 2) begin
         errors++;
         $display("FAIL bp_requests got %0d want 2", obs_issue.size());
      end
      repeat (10) step(1'b0, 1'b1, 8'h00);
      check_pcs("bp_order", 8'h00, 8);
   endtask

   task automatic test_flush();
      rom_linear();
      do_reset(8'h00);
      repeat (3) step(1'b0, 1'b0, 8'h00);
      obs_pc.delete();
      step(1'b1, 1'b1, 8'h40);
      repeat (6) step(1'b0, 1'b1, 8'h00);
      check_pcs("flush_full", 8'h40, 3);
      obs_pc.delete();
      step(1'b1, 1'b1, 8'h80);
      step(1'b1, 1'b1, 8'h90);
      repeat (6) step(1'b0, 1'b1, 8'h00);
      check_pcs("flush_drain", 8'h90, 3);
   endtask

   task automatic test_wrap();
      rom_linear();
      do_reset(8'hFE);
      repeat (6) step(1'b0, 1'b1, 8'h00);
      check_pcs("wrap", 8'hFE, 3);
   endtask

   task automatic test_midreset();
      rom_linear();
      do_reset(8'h20);
      repeat (3) step(1'b0, 1'b0, 8'h00);
      #2;
      reset_n = 1'b0;
      #1;
      check_zero("midreset");
      do_reset(8'h30);
      repeat (6) step(1'b0, 1'b1, 8'h00);
      check_pcs("midreset_fresh", 8'h30, 3);
   endtask

   task automatic test_random();
      for (int a = 0; a < 256; a++) rom[a] = 16'($urandom);
      do_reset(8'($urandom));
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
              8'($urandom));
      end
   endtask

`ifdef FETCH_HALT_DETECT_EN
   task automatic test_halt();
      rom_linear();
      rom[2] = 16'hF000;
      do_reset(8'h00);
      repeat (10) step(1'b0, 1'b1, 8'h00);
      checks++;
      if (obs_issue.size() != 3) begin
         errors++;
         $display("FAIL halt_requests got %0d want 3", obs_issue.size());
      end
      check_pcs("halt_deliver", 8'h00, 3);
      checks++;
      if (pc_stall !== 1'b1) begin
         errors++;
         $display("FAIL halt_stall got %b want 1", pc_stall);
      end
      obs_pc.delete();
      step(1'b1, 1'b1, 8'h10);
      repeat (6) step(1'b0, 1'b1, 8'h00);
      check_pcs("halt_restart", 8'h10, 3);
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_wrap();
      test_midreset();
`ifdef FETCH_HALT_DETECT_EN
      test_halt();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
